// File: rtl/downsample_pkg.sv
// Shared types and constants for the 2x2 average-pooling stream block.
package downsample_pkg;

   localparam logic [2:0] SZ_4  = 3'd0;
   localparam logic [2:0] SZ_8  = 3'd1;
   localparam logic [2:0] SZ_16 = 3'd2;
   localparam logic [2:0] SZ_32 = 3'd3;
   localparam logic [2:0] SZ_64 = 3'd4;

   localparam int DEF_DATA_WIDTH = 16;
   localparam int SUM_W          = DEF_DATA_WIDTH + 2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   // Unknown codes fall back to the smallest map.
   function automatic logic [6:0] side_len(input logic [2:0] code);
      case (code)
         SZ_8:    side_len = 7'd8;
         SZ_16:   side_len = 7'd16;
         SZ_32:   side_len = 7'd32;
         SZ_64:   side_len = 7'd64;
         default: side_len = 7'd4;
      endcase
   endfunction

endpackage

// File: rtl/pool_linebuf.sv
// One-row buffer of horizontal pair sums; synchronous write, asynchronous read.
module pool_linebuf #(
   parameter int WIDTH = 17,
   parameter int DEPTH = 32,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/downsample_pool_axi.sv
// AXI-Stream 2x2 floor-average pooling of one square channel, row-major in and out.
module downsample_pool_axi
   import downsample_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int MAX_SIZE   = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [2:0]            size_sel,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   input  logic                  s_axis_tlast,
   output logic                  s_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   output logic                  m_axis_tlast,
   input  logic                  m_axis_tready,
   output logic                  busy,
   output logic                  channel_done,
   output logic                  err_tlast
);

   localparam int CW = $clog2(MAX_SIZE);
   localparam int AW = CW - 1;
   localparam int PW = DATA_WIDTH + 1;
   localparam int SW = DATA_WIDTH + 2;

   state_t                 state;
   logic [2:0]             size_q;
   logic [CW-1:0]          col, row;
   logic [DATA_WIDTH-1:0]  hold_q;

   logic [2:0]             eff_size;
   logic [CW-1:0]          n_m1;
   logic                   accept, load, out_hs;
   logic                   col_last, row_last, beat_last;
   logic signed [PW-1:0]   pair, lb_rdata;
   logic signed [SW-1:0]   sum;
   logic                   lb_we;

   // The first beat of a channel is sized by the live size_sel, later beats by size_q.
   assign eff_size  = (state == S_IDLE) ? size_sel : size_q;
   assign n_m1      = CW'(side_len(eff_size) - 7'd1);
   assign col_last  = (col == n_m1);
   assign row_last  = (row == n_m1);
   assign beat_last = col_last && row_last;

   always_comb begin
      s_axis_tready = 1'b0;
      if (!reset) begin
         case (state)
            S_IDLE:  s_axis_tready = 1'b1;
            S_RUN:   s_axis_tready = !m_axis_tvalid || m_axis_tready;
            default: s_axis_tready = 1'b0;
         endcase
      end
   end

   assign accept = s_axis_tvalid && s_axis_tready;
   assign out_hs = m_axis_tvalid && m_axis_tready;
   assign load   = accept && row[0] && col[0];
   assign lb_we  = accept && col[0] && !row[0];

   assign pair = {hold_q[DATA_WIDTH-1], hold_q} +
                 {s_axis_tdata[DATA_WIDTH-1], s_axis_tdata};
   assign sum  = {lb_rdata[PW-1], lb_rdata} + {pair[PW-1], pair};

   pool_linebuf #(
      .WIDTH (PW),
      .DEPTH (MAX_SIZE / 2),
      .AW    (AW)
   ) u_linebuf (
      .clk   (clk),
      .we    (lb_we),
      .addr  (col[CW-1:1]),
      .wdata (pair),
      .rdata (lb_rdata)
   );

   assign busy = (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_IDLE;
         size_q        <= SZ_4;
         col           <= '0;
         row           <= '0;
         hold_q        <= '0;
         m_axis_tdata  <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         channel_done  <= 1'b0;
         err_tlast     <= 1'b0;
      end else begin
         channel_done <= 1'b0;

         if (accept) begin
            if (!col[0]) hold_q <= s_axis_tdata;
            if (col_last) begin
               col <= '0;
               row <= row_last ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
            if (s_axis_tlast != beat_last) err_tlast <= 1'b1;
         end

         // A reload in the same cycle as a handshake keeps tvalid high.
         if (load) begin
            m_axis_tdata  <= DATA_WIDTH'(sum >>> 2);
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= beat_last;
         end else if (out_hs) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
         end

         case (state)
            S_IDLE: begin
               if (accept) begin
                  size_q <= size_sel;
                  state  <= S_RUN;
               end
            end
            S_RUN: begin
               if (accept && beat_last) state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (out_hs) begin
                  channel_done <= 1'b1;
                  state        <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_downsample_pool_axi.sv
// Directed bench for downsample_pool_axi with an expected-output queue.
module tb_downsample_pool_axi;

   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [2:0]    size_sel = 3'd0;
   logic [DW-1:0] s_axis_tdata = '0;
   logic          s_axis_tvalid = 1'b0;
   logic          s_axis_tlast = 1'b0;
   logic          s_axis_tready;
   logic [DW-1:0] m_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tlast;
   logic          m_axis_tready = 1'b1;
   logic          busy;
   logic          channel_done;
   logic          err_tlast;

   downsample_pool_axi #(.DATA_WIDTH(DW), .MAX_SIZE(64)) dut (
      .clk           (clk),
      .reset         (reset),
      .size_sel      (size_sel),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tready (m_axis_tready),
      .busy          (busy),
      .channel_done  (channel_done),
      .err_tlast     (err_tlast)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int hs_cyc = 0;
   int out_cnt = 0;
   bit done_seen = 1'b0;
   bit ignore_out = 1'b0;
   bit rand_rdy = 1'b0;

   logic signed [DW-1:0] pix [0:4095];
   logic [DW:0]          exp_q [$];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         m_axis_tready = rand_rdy ? ($urandom_range(0, 99) >= 30) : 1'b1;
      end
   end

   // Output monitor: handshakes seen at the negedge complete on the next rising edge.
   always @(negedge clk) begin
      if (!reset) begin
         if (m_axis_tvalid && !m_axis_tready)
            check_val("stall_in_ready", 32'(s_axis_tready), 32'd0);
         if (m_axis_tvalid && m_axis_tready && !ignore_out) begin
            out_cnt++;
            hs_cyc = cyc;
            if (exp_q.size() == 0) begin
               check_val("unexpected_out", 32'(m_axis_tdata), 32'hffff_ffff);
            end else begin
               check_val("out_data", 32'(m_axis_tdata), 32'(exp_q[0][DW-1:0]));
               check_val("out_last", 32'(m_axis_tlast), 32'(exp_q[0][DW]));
               void'(exp_q.pop_front());
            end
         end
         if (channel_done && !ignore_out) begin
            done_seen = 1'b1;
            check_val("done_delay", 32'(cyc - hs_cyc), 32'd1);
         end
      end
   end

   task automatic fill_ramp(input int n);
      for (int i = 0; i < n * n; i++) pix[i] = DW'(i % 32768);
   endtask

   task automatic model_push(input int n);
      for (int r = 0; r < n / 2; r++) begin
         for (int c = 0; c < n / 2; c++) begin
            int s;
            logic [DW-1:0] v;
            logic lst;
            s = int'(pix[2*r*n + 2*c]) + int'(pix[2*r*n + 2*c + 1]) +
                int'(pix[(2*r+1)*n + 2*c]) + int'(pix[(2*r+1)*n + 2*c + 1]);
            v = DW'(s >>> 2);
            lst = (r == n / 2 - 1) && (c == n / 2 - 1);
            exp_q.push_back({lst, v});
         end
      end
   endtask

   task automatic push_exp(input logic [DW-1:0] v, input logic lst);
      exp_q.push_back({lst, v});
   endtask

   // Sends one channel; tlast can be forced on bad_beat or dropped on the final beat.
   task automatic drive_channel(input int n, input int bad_beat, input bit drop_last,
                                input int abort_at, input int sz_at, input logic [2:0] new_sz);
      for (int i = 0; i < n * n; i++) begin
         int to;
         bit hs;
         if (i == abort_at) begin
            s_axis_tvalid = 1'b0;
            reset = 1'b1;
            @(posedge clk);
            #1;
            reset = 1'b0;
            return;
         end
         if (i == sz_at) size_sel = new_sz;
         if (i == 5) check_val("busy_run", 32'(busy), 32'd1);
         s_axis_tdata  = pix[i];
         s_axis_tvalid = 1'b1;
         s_axis_tlast  = ((i == n * n - 1) && !drop_last) || (i == bad_beat);
         to = 0;
         hs = 1'b0;
         while (!hs && to < 1000) begin
            @(negedge clk);
            hs = s_axis_tready;
            to++;
         end
         if (!hs) begin
            check_val("in_timeout", 32'd0, 32'd1);
            s_axis_tvalid = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   task automatic wait_channel(input string tag, input int n_out);
      int to;
      to = 0;
      while (!(done_seen && exp_q.size() == 0) && to < 20000) begin
         @(posedge clk);
         to++;
      end
      check_val({tag, "_timeout"}, 32'(to >= 20000), 32'd0);
      check_val({tag, "_count"}, 32'(out_cnt), 32'(n_out));
      check_val({tag, "_queue"}, 32'(exp_q.size()), 32'd0);
      @(posedge clk);
      #1;
      check_val({tag, "_idle"}, 32'(busy), 32'd0);
      out_cnt = 0;
      done_seen = 1'b0;
   endtask

   initial begin
      // Reset values.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_val("rst_s_tready", 32'(s_axis_tready), 32'd0);
      check_val("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
      check_val("rst_m_tlast", 32'(m_axis_tlast), 32'd0);
      check_val("rst_done", 32'(channel_done), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_err", 32'(err_tlast), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check_val("idle_s_tready", 32'(s_axis_tready), 32'd1);
      @(posedge clk);
      #1;

      // 4x4 ramp: hand-computed averages.
      size_sel = 3'd0;
      fill_ramp(4);
      push_exp(16'd2, 1'b0);
      push_exp(16'd4, 1'b0);
      push_exp(16'd10, 1'b0);
      push_exp(16'd12, 1'b1);
      drive_channel(4, -1, 1'b0, -1, -1, 3'd0);
      wait_channel("ramp4", 4);
      check_val("ramp4_err", 32'(err_tlast), 32'd0);

      // Negative window, floor(-10/4) = -3.
      for (int i = 0; i < 16; i++) pix[i] = '0;
      pix[0] = -16'sd1;
      pix[1] = -16'sd2;
      pix[4] = -16'sd3;
      pix[5] = -16'sd4;
      push_exp(16'hfffd, 1'b0);
      push_exp(16'd0, 1'b0);
      push_exp(16'd0, 1'b0);
      push_exp(16'd0, 1'b1);
      drive_channel(4, -1, 1'b0, -1, -1, 3'd0);
      wait_channel("neg4", 4);

      // 64x64 ramp under random output backpressure.
      size_sel = 3'd4;
      fill_ramp(64);
      model_push(64);
      rand_rdy = 1'b1;
      drive_channel(64, -1, 1'b0, -1, -1, 3'd4);
      wait_channel("ramp64", 1024);
      rand_rdy = 1'b0;
      check_val("ramp64_err", 32'(err_tlast), 32'd0);

      // 8x8 with misplaced tlast: counting unaffected, flag sticky.
      size_sel = 3'd1;
      for (int i = 0; i < 64; i++) pix[i] = DW'(i * 37 - 1000);
      model_push(8);
      drive_channel(8, 10, 1'b1, -1, -1, 3'd1);
      wait_channel("tlast8", 16);
      check_val("tlast8_err", 32'(err_tlast), 32'd1);

      // size_sel change mid-channel is ignored; the next channel picks it up.
      size_sel = 3'd1;
      fill_ramp(8);
      model_push(8);
      drive_channel(8, -1, 1'b0, -1, 20, 3'd3);
      wait_channel("szchg8", 16);
      fill_ramp(32);
      model_push(32);
      drive_channel(32, -1, 1'b0, -1, -1, 3'd3);
      wait_channel("sz32", 256);
      check_val("err_sticky", 32'(err_tlast), 32'd1);

      // Reset mid-channel, then a clean 4x4 ramp.
      size_sel = 3'd2;
      fill_ramp(16);
      ignore_out = 1'b1;
      drive_channel(16, -1, 1'b0, 100, -1, 3'd2);
      @(negedge clk);
      check_val("midrst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
      check_val("midrst_busy", 32'(busy), 32'd0);
      check_val("midrst_err", 32'(err_tlast), 32'd0);
      ignore_out = 1'b0;
      out_cnt = 0;
      done_seen = 1'b0;
      @(posedge clk);
      #1;
      size_sel = 3'd0;
      fill_ramp(4);
      push_exp(16'd2, 1'b0);
      push_exp(16'd4, 1'b0);
      push_exp(16'd10, 1'b0);
      push_exp(16'd12, 1'b1);
      drive_channel(4, -1, 1'b0, -1, -1, 3'd0);
      wait_channel("postrst4", 4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "global timeout");
   end

endmodule
